// File: rtl/data_memory_responder_pkg.sv
// Shared types and lane helpers for the data memory responder.
// Optional range checking is enabled with the DMEM_BOUNDS_CHECK_EN macro (see top).
package data_memory_responder_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } memWidth_;

    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmemState_;

    function automatic logic [3:0] laneStrobe(input logic [1:0] width, input logic [1:0] offset);
        logic [3:0] base;
        case (width)
            MEM_BYTE: base = 4'b0001;
            MEM_HALF: base = 4'b0011;
            default:  base = 4'b1111;
        endcase
        return base << offset;
    endfunction

    function automatic logic [31:0] widthMask(input logic [1:0] width);
        logic [31:0] mask;
        case (width)
            MEM_BYTE: mask = 32'h0000_00FF;
            MEM_HALF: mask = 32'h0000_FFFF;
            default:  mask = 32'hFFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_memory_responder_dmem_sram.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
module dmem_sram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wData,
    output logic [31:0]       rData
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read-before-write: a store returns the old word, which the top discards anyway.
    always_ff @(posedge clk) begin
        if (en) begin
            rData <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wData[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-stage data port responder: FSM, latency counter, lane steering and error detection.
// Define DMEM_BOUNDS_CHECK_EN to flag accesses outside the RAM window instead of wrapping.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] reqAddr,
    input  logic        reqWrite,
    input  logic [1:0]  reqWidth,
    input  logic [31:0] reqWData,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspRData,
    output logic        rspError,
    output logic        busy
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [1:0] WAIT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    dmemState_   stateReg, stateNext;
    logic [1:0]  cntReg, cntNext;
    logic [31:0] addrReg, wDataReg;
    logic [1:0]  widthReg;
    logic        writeReg, errReg;

    logic        accept, enterResp;
    logic [31:0] curAddr, curWData, offset, laneData, ramRData;
    logic [1:0]  curWidth;
    logic        curWrite, misaligned, outOfRange, curErr;
    logic [3:0]  ramWe;

    assign reqReady = (stateReg == DMEM_IDLE);
    assign busy     = ~reqReady;
    assign accept   = reqValid && reqReady;

    // In IDLE the live request drives the RAM so that LATENCY==1 can commit on the accept edge.
    assign curAddr  = reqReady ? reqAddr  : addrReg;
    assign curWData = reqReady ? reqWData : wDataReg;
    assign curWidth = reqReady ? reqWidth : widthReg;
    assign curWrite = reqReady ? reqWrite : writeReg;

    assign offset     = curAddr - BASE_ADDR;
    assign misaligned = (curWidth == 2'b11)
                     || (curWidth == MEM_HALF && curAddr[0])
                     || (curWidth == MEM_WORD && curAddr[1:0] != 2'b00);

`ifdef DMEM_BOUNDS_CHECK_EN
    assign outOfRange = {1'b0, offset} >= (33'(DEPTH_WORDS) << 2);
`else
    logic unusedOffset;
    assign outOfRange   = 1'b0;
    assign unusedOffset = ^offset;
`endif

    assign curErr = misaligned || outOfRange;

    // resetN gating keeps a held request from writing the RAM while reset is asserted.
    assign enterResp = resetN && (((stateReg == DMEM_IDLE) && accept && (LATENCY == 1))
                               || ((stateReg == DMEM_WAIT) && (cntReg == 2'd0)));

    always_comb begin
        case (curWidth)
            MEM_BYTE: laneData = {4{curWData[7:0]}};
            MEM_HALF: laneData = {2{curWData[15:0]}};
            default:  laneData = curWData;
        endcase
        ramWe = (enterResp && curWrite && !curErr) ? laneStrobe(curWidth, curAddr[1:0]) : 4'b0000;
    end

    dmem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) uSram (
        .clk   (clk),
        .en    (enterResp),
        .we    (ramWe),
        .addr  (offset[IDX_W+1:2]),
        .wData (laneData),
        .rData (ramRData)
    );

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            DMEM_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        stateNext = DMEM_RESP;
                    end else begin
                        stateNext = DMEM_WAIT;
                        cntNext   = WAIT_INIT;
                    end
                end
            end
            DMEM_WAIT: begin
                if (cntReg == 2'd0) stateNext = DMEM_RESP;
                else                cntNext   = 2'(cntReg - 2'd1);
            end
            DMEM_RESP: begin
                if (rspReady) stateNext = DMEM_IDLE;
            end
            default: stateNext = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stateReg <= DMEM_IDLE;
            cntReg   <= 2'd0;
            addrReg  <= 32'd0;
            wDataReg <= 32'd0;
            widthReg <= 2'd0;
            writeReg <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (accept) begin
                addrReg  <= reqAddr;
                wDataReg <= reqWData;
                widthReg <= reqWidth;
                writeReg <= reqWrite;
            end
            if (enterResp) errReg <= curErr;
        end
    end

    // The RAM output register is only enabled on RESP entry, so the response holds while stalled.
    assign rspValid = (stateReg == DMEM_RESP);
    assign rspError = rspValid && errReg;
    assign rspRData = (rspValid && !writeReg && !errReg)
                    ? ((ramRData >> {addrReg[1:0], 3'b000}) & widthMask(widthReg))
                    : 32'd0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised bench: two responders (LATENCY 1 and 3, 16 words) against a byte-level memory model.
module tb_data_memory_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              resetN;
    logic [1:0]        reqValid, reqWrite, rspReady;
    logic [1:0]        reqReady, rspValid, rspError, busy;
    logic [1:0][31:0]  reqAddr, reqWData, rspRData;
    logic [1:0][1:0]   reqWidth;

    logic [31:0] model [2][DEPTH];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut0 (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid[0]), .reqReady(reqReady[0]), .reqAddr(reqAddr[0]),
        .reqWrite(reqWrite[0]), .reqWidth(reqWidth[0]), .reqWData(reqWData[0]),
        .rspValid(rspValid[0]), .rspReady(rspReady[0]), .rspRData(rspRData[0]),
        .rspError(rspError[0]), .busy(busy[0])
    );

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(BASE)) dut1 (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid[1]), .reqReady(reqReady[1]), .reqAddr(reqAddr[1]),
        .reqWrite(reqWrite[1]), .reqWidth(reqWidth[1]), .reqWData(reqWData[1]),
        .rspValid(rspValid[1]), .rspReady(rspReady[1]), .rspRData(rspRData[1]),
        .rspError(rspError[1]), .busy(busy[1])
    );

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed view of the RAM, wrap modulo DEPTH unless range checking is enabled.
    task automatic modelTxn(input int d, input logic [31:0] addr, input logic wr, input logic [1:0] width,
                            input logic [31:0] wdata, output logic [31:0] expR, output logic expE);
        logic [31:0] off, word;
        int idx, lane, nBytes;
        off    = addr - BASE;
        idx    = int'((off / 4) % DEPTH);
        lane   = int'(addr % 4);
        nBytes = (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
        expE   = (width == 2'd3) || (width == 2'd1 && addr % 2 != 0) || (width == 2'd2 && addr % 4 != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
        if (off >= 4 * DEPTH) expE = 1'b1;
`endif
        expR = 32'd0;
        if (!expE) begin
            if (wr) begin
                for (int b = 0; b < nBytes; b++) model[d][idx][8*(lane+b) +: 8] = wdata[8*b +: 8];
            end else begin
                word = model[d][idx];
                for (int b = 0; b < nBytes; b++) expR[8*b +: 8] = word[8*(lane+b) +: 8];
            end
        end
    endtask

    task automatic runTxn(input int d, input logic [31:0] addr, input logic wr, input logic [1:0] width,
                          input logic [31:0] wdata, input int hold, output logic [31:0] rd);
        logic [31:0] expR;
        logic expE, got;
        int k;
        modelTxn(d, addr, wr, width, wdata, expR, expE);
        @(negedge clk);
        checkVal("reqReady_idle", 32'(reqReady[d]), 32'd1);
        reqValid[d] = 1'b1; reqAddr[d] = addr; reqWrite[d] = wr;
        reqWidth[d] = width; reqWData[d] = wdata;
        @(posedge clk);
        #1 reqValid[d] = 1'b0;
        k = 0; got = 1'b0;
        while (k < 10 && !got) begin
            @(negedge clk);
            k++;
            if (rspValid[d]) got = 1'b1;
            else checkVal("busy_wait", 32'(busy[d]), 32'd1);
        end
        checkVal("latency", 32'(k), 32'(latOf(d)));
        rd = rspRData[d];
        checkVal("rdata", rspRData[d], expR);
        checkVal("error", 32'(rspError[d]), 32'(expE));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkVal("hold_valid", 32'(rspValid[d]), 32'd1);
            checkVal("hold_data", rspRData[d], expR);
            checkVal("hold_ready", 32'(reqReady[d]), 32'd0);
        end
        rspReady[d] = 1'b1;
        @(posedge clk);
        #1 rspReady[d] = 1'b0;
        @(negedge clk);
        checkVal("rsp_drop", 32'(rspValid[d]), 32'd0);
        $display("txn dut=%0d %s addr=%h width=%0d wdata=%h rdata=%h exp=%h err=%0d lat=%0d hold=%0d",
                 d, wr ? "ST" : "LD", addr, width, wdata, rd, expR, expE, k, hold);
    endtask

    task automatic checkResetValues(input int d);
        checkVal("rst_reqReady", 32'(reqReady[d]), 32'd1);
        checkVal("rst_rspValid", 32'(rspValid[d]), 32'd0);
        checkVal("rst_rspRData", rspRData[d], 32'd0);
        checkVal("rst_rspError", 32'(rspError[d]), 32'd0);
        checkVal("rst_busy", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, wdExp;
        int d, hold;
        reqValid = '0; reqWrite = '0; rspReady = '0;
        reqAddr = '0; reqWData = '0; reqWidth = '0;
        resetN = 1'b0;
        #1;
        checkResetValues(0);
        checkResetValues(1);
        repeat (3) @(negedge clk);
        resetN = 1'b1;

        for (int dd = 0; dd < 2; dd++)
            for (int i = 0; i < DEPTH; i++)
                runTxn(dd, BASE + 32'(4 * i), 1'b1, 2'd2, $urandom, 0, rd);

        // Word store/load round trip
        runTxn(0, BASE, 1'b1, 2'd2, 32'hDEADBEEF, 0, rd);
        runTxn(0, BASE, 1'b0, 2'd2, 32'd0, 0, rd);
        checkVal("t1_word", rd, 32'hDEADBEEF);

        // Byte merge into an existing word
        runTxn(0, BASE + 4, 1'b1, 2'd2, 32'h11223344, 0, rd);
        runTxn(0, BASE + 7, 1'b1, 2'd0, 32'h000000AA, 0, rd);
        runTxn(0, BASE + 4, 1'b0, 2'd2, 32'd0, 0, rd);
        checkVal("t2_word", rd, 32'hAA223344);
        runTxn(0, BASE + 7, 1'b0, 2'd0, 32'd0, 0, rd);
        checkVal("t2_byte", rd, 32'h000000AA);

        // Misaligned half, then memory unchanged
        runTxn(0, BASE + 1, 1'b0, 2'd1, 32'd0, 0, rd);
        checkVal("t3_err_data", rd, 32'd0);
        runTxn(0, BASE + 1, 1'b1, 2'd1, 32'h0000BBBB, 0, rd);
        runTxn(0, BASE, 1'b0, 2'd2, 32'd0, 0, rd);
        checkVal("t3_unchanged", rd, 32'hDEADBEEF);

        // Long stall on a LATENCY=3 store, then read back
        runTxn(1, BASE + 8, 1'b1, 2'd2, 32'h5A5AC3C3, 5, rd);
        runTxn(1, BASE + 8, 1'b0, 2'd2, 32'd0, 5, rd);
        checkVal("t4_store", rd, 32'h5A5AC3C3);

        // Reset during WAIT of a store: dropped
        @(negedge clk);
        reqValid[1] = 1'b1; reqAddr[1] = BASE + 8; reqWrite[1] = 1'b1;
        reqWidth[1] = 2'd2; reqWData[1] = 32'h12345678;
        @(posedge clk);
        #1 reqValid[1] = 1'b0;
        @(negedge clk);
        checkVal("t5_in_wait", 32'(busy[1]), 32'd1);
        resetN = 1'b0;
        #1;
        checkResetValues(1);
        checkResetValues(0);
        @(negedge clk);
        resetN = 1'b1;
        runTxn(1, BASE + 8, 1'b0, 2'd2, 32'd0, 0, rd);
        checkVal("t5_old_data", rd, 32'h5A5AC3C3);

        // Just past the window: flagged when range checking, wraps to word 0 otherwise
        runTxn(0, BASE + 32'h40, 1'b1, 2'd2, 32'hCAFEF00D, 0, rd);
        runTxn(0, BASE, 1'b0, 2'd2, 32'd0, 0, rd);
`ifdef DMEM_BOUNDS_CHECK_EN
        wdExp = 32'hDEADBEEF;
`else
        wdExp = 32'hCAFEF00D;
`endif
        checkVal("t6_wrap", rd, wdExp);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] addr;
            d    = int'($urandom_range(0, 1));
            hold = int'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) addr = BASE - 32'($urandom_range(1, 8));
            else                            addr = BASE + 32'($urandom_range(0, 79));
            runTxn(d, addr, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, hold, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
